sparc_exu_addseq: RTL

- Sequencer and arbiter for the shared 64-bit ALU adder (two operands, carry-in; outputs 64-bit sum, cout32, cout64).
- Two requesters stream multi-word (64-bit limb) add/subtract packets. The block grants the adder round-robin at packet boundaries and chains carry between words.
- It produces a registered result stream carrying carry, signed overflow and error flags.
- The adder stays an external combinational instance, driven through this block's add_* ports.

---
 rtl/sparc_exu_addseq_pkg.sv | 16 +
 rtl/sparc_exu_addseq_if.sv | 20 ++
 rtl/sparc_exu_addseq_rrarb.sv | 33 +++
 rtl/sparc_exu_addseq.sv | 135 +++++++++++++
 4 files changed

// File: rtl/sparc_exu_addseq_pkg.sv
// Shared types for the multi-word adder sequencer.
// State encoding, requester id width, word-count sizing.
package exu_addseq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int ID_W = 1;

  function automatic int cnt_w(input int max_words);
    return $clog2(max_words) + 1;
  endfunction

endpackage

// File: rtl/sparc_exu_addseq_if.sv
// Requester word stream: one 64-bit limb per vld&rdy beat.
// master = requester, slave = sequencer.
interface sparc_exu_addseq_if;
  logic        vld;
  logic        sub;
  logic        last;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        rdy;

  modport master (
    output vld, sub, last, rs1, rs2,
    input  rdy
  );

  modport slave (
    input  vld, sub, last, rs1, rs2,
    output rdy
  );
endinterface

// File: rtl/sparc_exu_addseq_rrarb.sv
// Two-way round-robin arbiter; the pointer moves
// away from the releasing requester at packet end.
module sparc_exu_addseq_rrarb
  import exu_addseq_pkg::*;
#(
  parameter logic [ID_W-1:0] ARB_INIT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req,
  input  logic            rel,
  input  logic [ID_W-1:0] rel_id,
  output logic            gnt_vld,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr_q <= ARB_INIT;
    else if (rel) ptr_q <= ~rel_id;
  end

  always_comb begin
    gnt_vld = |req;
    unique case (req)
      2'b11:   gnt_id = ptr_q;
      2'b10:   gnt_id = 1'b1;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/sparc_exu_addseq.sv
// Shared ALU adder sequencer: arbitrates packets, chains
// carry across limbs, registers the result stream.
module sparc_exu_addseq
  import exu_addseq_pkg::*;
#(
  parameter int MAX_WORDS = 4,
  parameter int ARB_INIT  = 0
) (
  input  logic        rclk,
  input  logic        arst_l,
  sparc_exu_addseq_if.slave req0,
  sparc_exu_addseq_if.slave req1,
  output logic [63:0] add_rs1,
  output logic [63:0] add_rs2,
  output logic        add_cin,
  input  logic [63:0] add_out,
  input  logic        add_cout32,
  input  logic        add_cout64,
  output logic        res_vld,
  output logic        res_id,
  output logic [63:0] res_data,
  output logic        res_last,
  output logic        res_cout,
  output logic        res_cout32,
  output logic        res_ovf,
  output logic        res_err
);

  localparam int CW = cnt_w(MAX_WORDS);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WORDS - 1);

  state_e          state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            gnt_vld;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] cur_id;
  logic            first, acc, cur_vld;
  logic            cur_sub, sub_in, cur_last;
  logic            pkt_end, forced, ovf;
  logic [63:0]     cur_rs1, cur_rs2;

  sparc_exu_addseq_rrarb #(
    .ARB_INIT (ID_W'(ARB_INIT))
  ) u_arb (
    .clk     (rclk),
    .rst_n   (arst_l),
    .req     ({req1.vld, req0.vld}),
    .rel     (acc & pkt_end),
    .rel_id  (cur_id),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q <= IDLE;
      owner_q <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    first    = (state_q == IDLE);
    cur_id   = first ? gnt_id : owner_q;
    cur_vld  = cur_id ? req1.vld  : req0.vld;
    sub_in   = cur_id ? req1.sub  : req0.sub;
    cur_last = cur_id ? req1.last : req0.last;
    cur_rs1  = cur_id ? req1.rs1  : req0.rs1;
    cur_rs2  = cur_id ? req1.rs2  : req0.rs2;
    req0.rdy = first ? (gnt_vld & ~gnt_id) : ~owner_q;
    req1.rdy = first ? (gnt_vld &  gnt_id) :  owner_q;
    acc      = first ? gnt_vld : cur_vld;
    cur_sub  = first ? sub_in : sub_q;
    add_rs1  = cur_rs1;
    add_rs2  = cur_sub ? ~cur_rs2 : cur_rs2;
    add_cin  = first ? cur_sub : carry_q;
    pkt_end  = cur_last | (cnt_q == LAST_CNT);
    forced   = ~cur_last & (cnt_q == LAST_CNT);
    ovf      = (add_rs1[63] == add_rs2[63]) &
               (add_out[63] != add_rs1[63]);
    if (acc) begin
      carry_d = add_cout64;
      if (pkt_end) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = BUSY;
        owner_d = cur_id;
        sub_d   = cur_sub;
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

  // Result fields are zeroed on idle cycles so the bus is quiet.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      res_vld    <= 1'b0;
      res_id     <= 1'b0;
      res_data   <= '0;
      res_last   <= 1'b0;
      res_cout   <= 1'b0;
      res_cout32 <= 1'b0;
      res_ovf    <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      res_vld    <= acc;
      res_id     <= acc & cur_id;
      res_data   <= acc ? add_out : '0;
      res_last   <= acc & pkt_end;
      res_cout   <= acc & (add_cout64 ^ cur_sub);
      res_cout32 <= acc & add_cout32;
      res_ovf    <= acc & pkt_end & ovf;
      res_err    <= acc & forced;
    end
  end

endmodule
